control_unit_spec: RTL and testbench

CONTROL_UNIT_SPEC -- requirements
Module: control_unit

---
 rtl/control_unit_spec.sv | 132 +++++++++++++
 tb/tb_control_unit_spec.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/control_unit_spec.sv
// RV32I main control decoder with one-cycle registered outputs and asynchronous active-low reset (en).
// Optional Illegal output is present only when CONTROL_UNIT_ILLEGAL_EN is defined.
module control_unit_spec (
    input  logic        clk,
    input  logic        en,
    input  logic [31:0] Ins,
    output logic        Branch,
    output logic        MemRead,
    output logic        MemtoReg,
    output logic [3:0]  alu_control,
    output logic        MemWrite,
    output logic        Is_Imm,
    output logic        RegWrite
`ifdef CONTROL_UNIT_ILLEGAL_EN
    ,
    output logic        Illegal
`endif
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_SUB  = 4'b1000;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       ins30;

    assign opcode = Ins[6:0];
    assign funct3 = Ins[14:12];
    assign ins30  = Ins[30];

    logic       branch_d,    branch_q;
    logic       mem_read_d,  mem_read_q;
    logic       mem_to_reg_d, mem_to_reg_q;
    logic       mem_write_d, mem_write_q;
    logic       is_imm_d,    is_imm_q;
    logic       reg_write_d, reg_write_q;
    logic [3:0] alu_d,       alu_q;
    logic       illegal_d,   illegal_q;

    always_comb begin
        branch_d     = 1'b0;
        mem_read_d   = 1'b0;
        mem_to_reg_d = 1'b0;
        mem_write_d  = 1'b0;
        is_imm_d     = 1'b0;
        reg_write_d  = 1'b0;
        alu_d        = ALU_ADD;
        illegal_d    = 1'b0;
        unique case (opcode)
            OP_R: begin
                reg_write_d = 1'b1;
                // funct7[5] selects SUB/SRA only; it is ignored for the other ops
                alu_d = {((funct3 == 3'b000) || (funct3 == 3'b101)) ? ins30 : 1'b0, funct3};
            end
            OP_I: begin
                is_imm_d    = 1'b1;
                reg_write_d = 1'b1;
                // imm[10] is data for addi, only SRAI uses it as an op select
                alu_d = {(funct3 == 3'b101) ? ins30 : 1'b0, funct3};
            end
            OP_LOAD: begin
                mem_read_d   = 1'b1;
                mem_to_reg_d = 1'b1;
                is_imm_d     = 1'b1;
                reg_write_d  = 1'b1;
            end
            OP_STORE: begin
                mem_write_d = 1'b1;
                is_imm_d    = 1'b1;
            end
            OP_BRANCH: begin
                branch_d = 1'b1;
                unique case (funct3)
                    3'b100, 3'b101: alu_d = ALU_SLT;
                    3'b110, 3'b111: alu_d = ALU_SLTU;
                    3'b000, 3'b001: alu_d = ALU_SUB;
                    default: begin
                        alu_d     = ALU_SUB;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            default: illegal_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge en) begin
        if (!en) begin
            branch_q     <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_to_reg_q <= 1'b0;
            mem_write_q  <= 1'b0;
            is_imm_q     <= 1'b0;
            reg_write_q  <= 1'b0;
            alu_q        <= 4'b0000;
            illegal_q    <= 1'b0;
        end else begin
            branch_q     <= branch_d;
            mem_read_q   <= mem_read_d;
            mem_to_reg_q <= mem_to_reg_d;
            mem_write_q  <= mem_write_d;
            is_imm_q     <= is_imm_d;
            reg_write_q  <= reg_write_d;
            alu_q        <= alu_d;
            illegal_q    <= illegal_d;
        end
    end

    assign Branch      = branch_q;
    assign MemRead     = mem_read_q;
    assign MemtoReg    = mem_to_reg_q;
    assign MemWrite    = mem_write_q;
    assign Is_Imm      = is_imm_q;
    assign RegWrite    = reg_write_q;
    assign alu_control = alu_q;

`ifdef CONTROL_UNIT_ILLEGAL_EN
    assign Illegal = illegal_q;
`else
    logic unused_illegal;
    assign unused_illegal = illegal_q;
`endif

endmodule

// File: tb/tb_control_unit_spec.sv
// Directed bench for control_unit_spec: reset, per-opcode decode, branch variants, unknown opcodes,
// mid-cycle Ins glitches and asynchronous reset assertion.
module tb_control_unit_spec;

    logic        clk;
    logic        en;
    logic [31:0] Ins;
    logic        Branch, MemRead, MemtoReg, MemWrite, Is_Imm, RegWrite;
    logic [3:0]  alu_control;
`ifdef CONTROL_UNIT_ILLEGAL_EN
    logic        Illegal;
    localparam logic [10:0] EXP_MASK = 11'h7FF;
`else
    localparam logic [10:0] EXP_MASK = 11'h3FF;
`endif

    int total = 0;
    int bad   = 0;

    control_unit_spec dut (
        .clk         (clk),
        .en          (en),
        .Ins         (Ins),
        .Branch      (Branch),
        .MemRead     (MemRead),
        .MemtoReg    (MemtoReg),
        .alu_control (alu_control),
        .MemWrite    (MemWrite),
        .Is_Imm      (Is_Imm),
        .RegWrite    (RegWrite)
`ifdef CONTROL_UNIT_ILLEGAL_EN
        ,
        .Illegal     (Illegal)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packed view: {Illegal, Branch, MemRead, MemtoReg, MemWrite, Is_Imm, RegWrite, alu_control}
    function automatic logic [10:0] observed();
        logic ill;
`ifdef CONTROL_UNIT_ILLEGAL_EN
        ill = Illegal;
`else
        ill = 1'b0;
`endif
        return {ill, Branch, MemRead, MemtoReg, MemWrite, Is_Imm, RegWrite, alu_control};
    endfunction

    task automatic drive(input logic [31:0] w);
        @(negedge clk);
        Ins = w;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [10:0] obs;
        en  = 1'b0;
        Ins = 32'h415A04B3;
        repeat (3) @(posedge clk);
        #1;
        obs = observed();
        total++;
        if (obs !== 11'h000) begin
            bad++;
            $display("FAIL reset_hold: got %h want %h", obs, 11'h000);
        end
        @(negedge clk);
        en = 1'b1;
        #3;
        obs = observed();
        total++;
        if (obs !== 11'h000) begin
            bad++;
            $display("FAIL reset_release_before_edge: got %h want %h", obs, 11'h000);
        end
        @(posedge clk);
        #1;
        obs = observed();
        total++;
        if (obs !== 11'b0_000001_1000) begin
            bad++;
            $display("FAIL reset_first_decode: got %h want %h", obs, 11'b0_000001_1000);
        end
    endtask

    task automatic test_rtype();
        logic [31:0] ins_t[5] = '{32'h415A04B3, 32'h015A14B3, 32'h40005033, 32'h00005033, 32'h40004033};
        logic [10:0] exp_t[5] = '{11'b0_000001_1000, 11'b0_000001_0001, 11'b0_000001_1101,
                                  11'b0_000001_0101, 11'b0_000001_0100};
        logic [10:0] obs;
        for (int i = 0; i < 5; i++) begin
            drive(ins_t[i]);
            obs = observed();
            total++;
            if (obs !== (exp_t[i] & EXP_MASK)) begin
                bad++;
                $display("FAIL rtype[%0d] ins=%h: got %h want %h", i, ins_t[i], obs, exp_t[i] & EXP_MASK);
            end
        end
    endtask

    task automatic test_ialu();
        logic [31:0] ins_t[4] = '{32'h015A0493, 32'h40000013, 32'h40005013, 32'h00007013};
        logic [10:0] exp_t[4] = '{11'b0_000011_0000, 11'b0_000011_0000, 11'b0_000011_1101,
                                  11'b0_000011_0111};
        logic [10:0] obs;
        for (int i = 0; i < 4; i++) begin
            drive(ins_t[i]);
            obs = observed();
            total++;
            if (obs !== (exp_t[i] & EXP_MASK)) begin
                bad++;
                $display("FAIL ialu[%0d] ins=%h: got %h want %h", i, ins_t[i], obs, exp_t[i] & EXP_MASK);
            end
        end
    endtask

    task automatic test_mem();
        logic [31:0] ins_t[4] = '{32'h015A14A3, 32'h00052483, 32'h00005003, 32'h4000F023};
        logic [10:0] exp_t[4] = '{11'b0_000110_0000, 11'b0_011011_0000, 11'b0_011011_0000,
                                  11'b0_000110_0000};
        logic [10:0] obs;
        for (int i = 0; i < 4; i++) begin
            drive(ins_t[i]);
            obs = observed();
            total++;
            if (obs !== (exp_t[i] & EXP_MASK)) begin
                bad++;
                $display("FAIL mem[%0d] ins=%h: got %h want %h", i, ins_t[i], obs, exp_t[i] & EXP_MASK);
            end
        end
    endtask

    task automatic test_branch();
        logic [31:0] ins_t[8];
        logic [10:0] exp_t[8] = '{11'b0_100000_1000, 11'b0_100000_1000, 11'b1_100000_1000,
                                  11'b1_100000_1000, 11'b0_100000_0010, 11'b0_100000_0010,
                                  11'b0_100000_0011, 11'b0_100000_0011};
        logic [10:0] obs;
        for (int f = 0; f < 8; f++) ins_t[f] = 32'h015A0063 | (32'(f) << 12);
        for (int i = 0; i < 8; i++) begin
            drive(ins_t[i]);
            obs = observed();
            total++;
            if (obs !== (exp_t[i] & EXP_MASK)) begin
                bad++;
                $display("FAIL branch_f3_%0d ins=%h: got %h want %h", i, ins_t[i], obs, exp_t[i] & EXP_MASK);
            end
        end
        drive(32'h015A04E3);
        obs = observed();
        total++;
        if (obs !== 11'b0_100000_1000) begin
            bad++;
            $display("FAIL branch_beq: got %h want %h", obs, 11'b0_100000_1000);
        end
    endtask

    task automatic test_unknown();
        logic [31:0] ins_t[3] = '{32'hFFFFFFFF, 32'h00000037, 32'h4000006F};
        logic [10:0] obs;
        for (int i = 0; i < 3; i++) begin
            drive(32'h415A04B3);
            drive(ins_t[i]);
            obs = observed();
            total++;
            if (obs !== (11'b1_000000_0000 & EXP_MASK)) begin
                bad++;
                $display("FAIL unknown[%0d] ins=%h: got %h want %h", i, ins_t[i], obs,
                         11'b1_000000_0000 & EXP_MASK);
            end
        end
    endtask

    task automatic test_glitch();
        logic [10:0] obs;
        drive(32'h00052483);
        @(negedge clk);
        Ins = 32'h415A04B3;
        #1 Ins = 32'hFFFFFFFF;
        #1;
        obs = observed();
        total++;
        if (obs !== 11'b0_011011_0000) begin
            bad++;
            $display("FAIL glitch_no_comb_path: got %h want %h", obs, 11'b0_011011_0000);
        end
        #1 Ins = 32'h415A04B3;
        @(posedge clk);
        #1;
        obs = observed();
        total++;
        if (obs !== 11'b0_000001_1000) begin
            bad++;
            $display("FAIL glitch_pulse_ignored: got %h want %h", obs, 11'b0_000001_1000);
        end
        @(negedge clk);
        Ins = 32'h415A04B3;
        #4 Ins = 32'h015A14A3;
        @(posedge clk);
        #1 Ins = 32'h415A04B3;
        #1;
        obs = observed();
        total++;
        if (obs !== 11'b0_000110_0000) begin
            bad++;
            $display("FAIL glitch_edge_value: got %h want %h", obs, 11'b0_000110_0000);
        end
    endtask

    task automatic test_async_reset();
        logic [10:0] obs;
        drive(32'h015A0493);
        #2 en = 1'b0;
        #1;
        obs = observed();
        total++;
        if (obs !== 11'h000) begin
            bad++;
            $display("FAIL async_reset_immediate: got %h want %h", obs, 11'h000);
        end
        @(posedge clk);
        #1;
        obs = observed();
        total++;
        if (obs !== 11'h000) begin
            bad++;
            $display("FAIL async_reset_held: got %h want %h", obs, 11'h000);
        end
        @(negedge clk);
        en = 1'b1;
        @(posedge clk);
        #1;
        obs = observed();
        total++;
        if (obs !== 11'b0_000011_0000) begin
            bad++;
            $display("FAIL async_reset_recover: got %h want %h", obs, 11'b0_000011_0000);
        end
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        en  = 1'b0;
        Ins = 32'h0;
        test_reset();
        test_rtype();
        test_ialu();
        test_mem();
        test_branch();
        test_unknown();
        test_glitch();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
